// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Round-robin on ties; reads take a second cycle to return data to their owner.
//
// state | meaning
// IDLE  | may grant one requester per cycle; writes complete here
// RD    | read response cycle for the registered owner; no grants
module dmem_arbiter #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_t;

  state_t      state;
  logic        last_gnt;
  logic        owner;
  logic        rd_err;
  logic [1:0]  wr_err;

  logic        idle_ok;
  logic        rsp_live;
  logic        accept;
  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        in_range;

  // Grant and memory command path; everything is forced to 0 while rst is high.
  always_comb begin
    idle_ok    = (state == IDLE) && !rst;
    m0_gnt     = idle_ok && m0_req && (!m1_req || last_gnt);
    m1_gnt     = idle_ok && m1_req && (!m0_req || !last_gnt);
    accept     = m0_gnt || m1_gnt;
    sel        = m1_gnt;
    sel_we     = sel ? m1_we    : m0_we;
    sel_addr   = sel ? m1_addr  : m0_addr;
    sel_wdata  = sel ? m1_wdata : m0_wdata;
    in_range   = sel_addr < DEPTH_W;
    MemWrite   = accept && sel_we && in_range;
    MemRead    = accept && !sel_we && in_range;
    address    = (MemRead || MemWrite) ? sel_addr : 32'd0;
    write_data = MemWrite ? sel_wdata : 32'd0;
  end

  always_comb begin
    rsp_live  = (state == RD) && !rst;
    m0_rvalid = rsp_live && !owner;
    m1_rvalid = rsp_live && owner;
    m0_err    = !rst && ((m0_rvalid && rd_err) || wr_err[0]);
    m1_err    = !rst && ((m1_rvalid && rd_err) || wr_err[1]);
    m0_rdata  = (m0_rvalid && !rd_err) ? read_data : 32'd0;
    m1_rdata  = (m1_rvalid && !rd_err) ? read_data : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      owner    <= 1'b0;
      rd_err   <= 1'b0;
      wr_err   <= 2'b00;
    end else begin
      wr_err <= 2'b00;
      case (state)
        IDLE: begin
          if (accept) begin
            last_gnt <= sel;
            owner    <= sel;
            if (!sel_we) begin
              state  <= RD;
              rd_err <= !in_range;
            end else if (!in_range) begin
              wr_err[sel] <= 1'b1;
            end
          end
        end
        RD: begin
          state  <= IDLE;
          rd_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes hand-computed command and
// response expectations; a negedge monitor pops them as the DUT presents activity.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] address, write_data;
  logic [31:0] read_data;

  dmem_arbiter #(.DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_err(m0_err), .m1_err(m1_err),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .write_data(write_data),
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Memory behind the arbiter: registered read, valid the cycle after MemRead.
  logic [31:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + 32'(i);
    read_data = 32'd0;
  end
  always @(posedge clk) begin
    if (MemRead)  read_data <= mem[address[5:0]];
    if (MemWrite) mem[address[5:0]] <= write_data;
  end

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  typedef struct packed {
    logic [31:0] cyc;
    logic        g0, g1, rd, wr;
    logic [31:0] addr, wd;
  } cmd_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        v0, v1, e0, e1;
    logic [31:0] d0, d1;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push_cmd(input logic [31:0] c, input logic g0, input logic g1,
                          input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd);
    cmd_t e;
    e.cyc = c; e.g0 = g0; e.g1 = g1; e.rd = rd; e.wr = wr; e.addr = a; e.wd = wd;
    cmd_q.push_back(e);
  endtask

  task automatic push_rsp(input logic [31:0] c, input logic v0, input logic v1,
                          input logic e0, input logic e1,
                          input logic [31:0] d0, input logic [31:0] d1);
    rsp_t e;
    e.cyc = c; e.v0 = v0; e.v1 = v1; e.e0 = e0; e.e1 = e1; e.d0 = d0; e.d1 = d1;
    rsp_q.push_back(e);
  endtask

  // Monitor: any command or response activity must match the next expectation.
  always @(negedge clk) begin
    cmd_t gc, ec;
    rsp_t gr, er;
    gc = '{cyc, m0_gnt, m1_gnt, MemRead, MemWrite, address, write_data};
    gr = '{cyc, m0_rvalid, m1_rvalid, m0_err, m1_err, m0_rdata, m1_rdata};
    if (m0_gnt || m1_gnt || MemRead || MemWrite || address != 0 || write_data != 0) begin
      n_checks++;
      if (cmd_q.size() == 0) begin
        n_fail++;
        $display("FAIL cmd_unexpected: got cyc=%0d g0=%b g1=%b rd=%b wr=%b addr=%h wd=%h, required none",
                 gc.cyc, gc.g0, gc.g1, gc.rd, gc.wr, gc.addr, gc.wd);
      end else begin
        ec = cmd_q.pop_front();
        if (gc !== ec) begin
          n_fail++;
          $display("FAIL cmd: got cyc=%0d g0=%b g1=%b rd=%b wr=%b addr=%h wd=%h, required cyc=%0d g0=%b g1=%b rd=%b wr=%b addr=%h wd=%h",
                   gc.cyc, gc.g0, gc.g1, gc.rd, gc.wr, gc.addr, gc.wd,
                   ec.cyc, ec.g0, ec.g1, ec.rd, ec.wr, ec.addr, ec.wd);
        end
      end
    end
    if (m0_rvalid || m1_rvalid || m0_err || m1_err || m0_rdata != 0 || m1_rdata != 0) begin
      n_checks++;
      if (rsp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got cyc=%0d v0=%b v1=%b e0=%b e1=%b d0=%h d1=%h, required none",
                 gr.cyc, gr.v0, gr.v1, gr.e0, gr.e1, gr.d0, gr.d1);
      end else begin
        er = rsp_q.pop_front();
        if (gr !== er) begin
          n_fail++;
          $display("FAIL rsp: got cyc=%0d v0=%b v1=%b e0=%b e1=%b d0=%h d1=%h, required cyc=%0d v0=%b v1=%b e0=%b e1=%b d0=%h d1=%h",
                   gr.cyc, gr.v0, gr.v1, gr.e0, gr.e1, gr.d0, gr.d1,
                   er.cyc, er.v0, er.v1, er.e0, er.e1, er.d0, er.d1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string name);
    logic [139:0] outs;
    @(negedge clk);
    outs = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, MemRead, MemWrite,
            m0_rdata, m1_rdata, address, write_data};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL %s: got outputs=%h, required all zero", name, outs);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  logic [31:0] c;

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    m0_req = 1; m1_req = 1; m0_addr = 5; m1_addr = 7;
    check_quiet("reset_outputs_a");
    step();
    check_quiet("reset_outputs_b");

    // write then read back addr 5 on m0
    step();
    rst = 0; idle_inputs();
    c = cyc;
    m0_req = 1; m0_we = 1; m0_addr = 5; m0_wdata = 32'hDEADBEEF;
    push_cmd(c,     1, 0, 0, 1, 32'd5, 32'hDEADBEEF);
    push_cmd(c + 1, 1, 0, 1, 0, 32'd5, 32'd0);
    push_rsp(c + 2, 1, 0, 0, 0, 32'hDEADBEEF, 32'd0);
    step(); m0_we = 0;
    step(); idle_inputs();
    step();

    // reset, then both read continuously: m0, m1 alternate every 2 cycles
    rst = 1;
    step();
    rst = 0;
    c = cyc;
    m0_req = 1; m0_addr = 5; m1_req = 1; m1_addr = 7;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        push_cmd(c + 32'(2*k), 1, 0, 1, 0, 32'd5, 32'd0);
        push_rsp(c + 32'(2*k+1), 1, 0, 0, 0, 32'hDEADBEEF, 32'd0);
      end else begin
        push_cmd(c + 32'(2*k), 0, 1, 1, 0, 32'd7, 32'd0);
        push_rsp(c + 32'(2*k+1), 0, 1, 0, 0, 32'd0, 32'hA500_0007);
      end
    end
    for (int k = 0; k < 11; k++) step();
    idle_inputs();
    step();

    // m1 back-to-back writes to 0..3, then reads addr 2
    c = cyc;
    m1_req = 1; m1_we = 1;
    for (int k = 0; k < 4; k++) begin
      m1_addr = 32'(k); m1_wdata = 32'h1000 + 32'(k);
      push_cmd(c + 32'(k), 0, 1, 0, 1, 32'(k), 32'h1000 + 32'(k));
      step();
    end
    m1_we = 0; m1_addr = 2;
    push_cmd(c + 4, 0, 1, 1, 0, 32'd2, 32'd0);
    push_rsp(c + 5, 0, 1, 0, 0, 32'd0, 32'h1002);
    step(); idle_inputs();
    step();

    // out-of-range read on m0, out-of-range write on m1
    c = cyc;
    m0_req = 1; m0_we = 0; m0_addr = 64;
    push_cmd(c,     1, 0, 0, 0, 32'd0, 32'd0);
    push_rsp(c + 1, 1, 0, 1, 0, 32'd0, 32'd0);
    step(); idle_inputs();
    step();
    m1_req = 1; m1_we = 1; m1_addr = 100; m1_wdata = 32'h55;
    push_cmd(c + 2, 0, 1, 0, 0, 32'd0, 32'd0);
    push_rsp(c + 3, 0, 0, 0, 1, 32'd0, 32'd0);
    step(); idle_inputs();
    step();

    // both write every cycle: last grant was m1, so m0, m1, m0
    c = cyc;
    m0_req = 1; m0_we = 1; m0_addr = 10; m0_wdata = 32'hA;
    m1_req = 1; m1_we = 1; m1_addr = 11; m1_wdata = 32'hB;
    push_cmd(c,     1, 0, 0, 1, 32'd10, 32'hA);
    push_cmd(c + 1, 0, 1, 0, 1, 32'd11, 32'hB);
    push_cmd(c + 2, 1, 0, 0, 1, 32'd10, 32'hA);
    step(); step(); step();
    idle_inputs();
    step();

    // read granted, reset in the following cycle: no response, m0 wins after
    c = cyc;
    m0_req = 1; m0_addr = 5;
    push_cmd(c, 1, 0, 1, 0, 32'd5, 32'd0);
    step();
    rst = 1; m1_req = 1; m1_addr = 7;
    check_quiet("reset_kills_read");
    step();
    rst = 0;
    push_cmd(c + 2, 1, 0, 1, 0, 32'd5, 32'd0);
    push_rsp(c + 3, 1, 0, 0, 0, 32'hDEADBEEF, 32'd0);
    step(); idle_inputs();
    step();

    // m1 request raised and dropped during m0's RD cycle is ignored
    c = cyc;
    m0_req = 1; m0_addr = 1;
    push_cmd(c,     1, 0, 1, 0, 32'd1, 32'd0);
    push_rsp(c + 1, 1, 0, 0, 0, 32'h1001, 32'd0);
    step();
    m0_req = 0; m1_req = 1; m1_we = 1; m1_addr = 20; m1_wdata = 32'h77;
    step(); idle_inputs();
    for (int k = 0; k < 4; k++) step();

    @(negedge clk);
    n_checks++;
    if (cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL cmd_outstanding: got %0d unmatched command expectations, required 0", cmd_q.size());
    end
    n_checks++;
    if (rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_outstanding: got %0d unmatched response expectations, required 0", rsp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words in the data memory; valid word addresses are 0..DEPTH-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m0_req / m1_req  input  1  requester N wants one memory transfer; held with its command fields until granted.
REQ-005 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-006 m0_addr / m1_addr  input  32  word address.
REQ-007 m0_wdata / m1_wdata  input  32  write data.
REQ-008 m0_gnt / m1_gnt  output  1  combinational; transfer accepted in any cycle where mN_req and mN_gnt are both high.
REQ-009 m0_rvalid / m1_rvalid  output  1  one-cycle pulse; read response present.
REQ-010 m0_rdata / m1_rdata  output  32  read data, qualified by mN_rvalid, else 0.
REQ-011 m0_err / m1_err  output  1  one-cycle pulse; the accepted transfer had an out-of-range address.
REQ-012 MemRead, MemWrite  output  1 each  memory command strobes.
REQ-013 address, write_data  output  32 each  memory command fields.
REQ-014 read_data  input  32  memory read port; registered in memory, valid the cycle after MemRead is sampled.

Function
REQ-015 The FSM SHALL have two states: IDLE (may grant) and RD (read response cycle); gnt SHALL be 0 to both requesters in RD.
REQ-016 In IDLE with exactly one req high, that requester SHALL be granted the same cycle.
REQ-017 In IDLE with both req high, the requester not most recently granted SHALL be granted (round-robin); the last-grant pointer SHALL update on every accepted transfer.
REQ-018 At most one gnt SHALL be high in any cycle.
REQ-019 On an accepted in-range write, MemWrite=1, address=mN_addr, and write_data=mN_wdata SHALL be driven that cycle; the FSM SHALL stay in IDLE, so back-to-back writes are possible every cycle.
REQ-020 On an accepted in-range read, MemRead=1 and address=mN_addr SHALL be driven that cycle, and the FSM SHALL enter RD.
REQ-021 In RD, the owning requester SHALL see rvalid=1 and rdata=read_data; the FSM SHALL return to IDLE next cycle, giving read throughput of one per 2 cycles.
REQ-022 With no accepted transfer, MemRead, MemWrite, address and write_data SHALL all be 0.
REQ-023 An accepted transfer with addr >= DEPTH SHALL drive no MemRead or MemWrite.
REQ-024 For an out-of-range write, mN_err SHALL pulse in the following cycle and the FSM SHALL stay in IDLE.
REQ-025 For an out-of-range read, the FSM SHALL enter RD, and the RD cycle SHALL show rvalid=1, err=1 and rdata=0.
REQ-026 Response ownership (which requester receives rvalid/err) SHALL be registered at acceptance and SHALL not depend on req levels in the response cycle.
REQ-027 A req dropped before grant SHALL be ignored without error; a req held high after acceptance SHALL be treated as a new transfer.

Reset
REQ-028 While rst=1 at a clock edge, the next state SHALL be: FSM=IDLE, last-grant pointer=1 (so m0 wins the first tie), pending owner and error flags cleared.
REQ-029 While rst is high, all outputs SHALL be 0, including gnt, MemRead and MemWrite.
REQ-030 A read accepted in the cycle before a reset SHALL produce no rvalid or err afterwards.

Verification
REQ-031 m0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> write cycle shows MemWrite=1, address=5; two cycles later m0_rvalid=1, m0_rdata=0xDEADBEEF.
REQ-032 m0 and m1 both request reads continuously from reset -> grants alternate m0, m1, m0, ... with one grant every 2 cycles and no gnt in RD cycles.
REQ-033 m1 issues 4 back-to-back writes to addrs 0..3 -> MemWrite=1 on 4 consecutive cycles, m1_gnt high throughout, no rvalid.
REQ-034 m0 reads addr 64 (DEPTH=64) -> MemRead stays 0; next cycle m0_rvalid=1, m0_err=1, m0_rdata=0. m1 writes addr 100 -> one-cycle m1_err pulse, MemWrite stays 0.
REQ-035 rst asserted in the cycle after a read grant -> no rvalid is produced; after rst is released, simultaneous requests grant m0 first.
